rat_io_timer_int: RTL and testbench
===================================

# rat_io_timer_int

I/O-mapped timer and interrupt-request peripheral for the RAT CPU. It is the responder on the CPU's port bus: it accepts OUT writes qualified by IO_STRB, and returns register contents on IN reads through PORT_ID decode. It merges a programmable 16-bit prescaled down-counter and one debounced-free external event line into INT_CU, the interrupt request the CONTROL_UNIT samples.

## Interface
- PRESCALE, 50, CLK cycles per timer tick (≥2)
- P_RLD_LO, 8'hB0, reload low byte (R/W)
- P_RLD_HI, 8'hB1, reload high byte (R/W)
- P_CTRL, 8'hB2, control (R/W)
- P_STAT, 8'hB3, status read / write-1-to-clear ack
- P_CNT_LO / P_CNT_HI, 8'hB4 / 8'hB5, live count (R only)

Ports:
- CLK  in  1  clock
- RESET  in  1  synchronous, active-high reset
- IO_STRB  in  1  one-cycle write strobe from CPU
- PORT_ID  in  8  port address
- OUT_PORT  in  8  write data
- IN_DATA  out  8  read data for matched PORT_ID, else 8'h00 (OR-combined at top)
- INT_EXT  in  1  asynchronous external event, rising-edge significant
- INT_CU  out  1  interrupt request to CPU

## Operation
- CTRL bits: [0] EN, [1] AUTO (periodic reload), [4] TMR_IE, [5] EXT_IE; other bits read 0.
- STAT read: [0] TMR_PEND, [1] EXT_PEND, [2] RUNNING (state==ST_RUN). STAT write: each 1 bit clears the matching pending bit.
- Write to a port = IO_STRB=1 and PORT_ID match at a rising edge; unmatched writes are ignored.
- IN_DATA is combinational from PORT_ID; it is independent of IO_STRB.
- INT_CU = (TMR_PEND & TMR_IE) | (EXT_PEND & EXT_IE), combinational from registers.
- FSM states:
  - ST_IDLE: no counting. A CTRL write with EN=1 → ST_LOAD.
  - ST_LOAD: COUNT←RELOAD, PRE←0 → ST_RUN.
  - ST_RUN: PRE increments each cycle. A tick occurs when PRE==PRESCALE-1 (PRE→0). On a tick with COUNT>0, COUNT decrements. On a tick with COUNT==0, TMR_PEND←1; then if AUTO, COUNT←RELOAD and stay in ST_RUN; else EN←0 → ST_IDLE.
  - Any state: a CTRL write with EN=0 → ST_IDLE next cycle. COUNT and PRE hold their values.
- RELOAD writes while running affect only the next load/reload.
- RELOAD=0: expires on the first tick.
- A CTRL write with EN=1 while already in ST_RUN restarts via ST_LOAD.
- External path: INT_EXT passes through a 2-flop synchronizer, then a rising-edge detect; the edge sets EXT_PEND.
- Simultaneous set and W1C of the same pending bit: set wins (bit stays 1).
- Reset: all registers 0. State ST_IDLE, IN_DATA 8'h00 (for unmatched ports), INT_CU 0, synchronizer flops 0. Reset during ST_RUN aborts with no pending set.

## Timing
- Register writes are visible on IN_DATA the cycle after the strobe edge.
- Timer, one-shot: a CTRL write at edge E0 gives ST_LOAD after E0, ST_RUN after E0+1, and TMR_PEND set at edge E0+1+(RELOAD+1)·PRESCALE. INT_CU rises in the same cycle if TMR_IE=1.
- AUTO period: (RELOAD+1)·PRESCALE cycles between TMR_PEND set edges.
- External: a rising INT_EXT sampled at edge S sets EXT_PEND at edge S+2. INT_EXT high pulses must last ≥1 CLK period to be guaranteed.
- Ack: a STAT W1C at edge A drops INT_CU after A, unless a new set occurs at A.

## Structure
- Package rat_io_pkg: port address localparams, CTRL/STAT bit index constants, and the state enum (ST_IDLE, ST_LOAD, ST_RUN). These are shared with future RAT I/O peripherals.
- Sub-module rat_sync_edge: 2-flop synchronizer plus rising-edge pulse output, with its own RESET. It is reused by other asynchronous inputs.
- The top-level board wrapper ORs IN_DATA with the other peripherals' read buses.

## Test plan
- Reset: assert RESET for 2 cycles → INT_CU=0; reads of P_CTRL, P_STAT, P_CNT_LO all give 8'h00.
- One-shot (PRESCALE=4): write RLD=16'h0002, then CTRL=8'h11 at E0 → TMR_PEND and INT_CU rise at E0+13. Afterwards STAT reads 8'h01 and CTRL reads 8'h10.
- Periodic: RLD=1, CTRL=8'h13, PRESCALE=4 → TMR_PEND set every 8 cycles. W1C 8'h01 written on the same edge as an expiry → pending remains 1.
- External: CTRL=8'h20; raise INT_EXT before edge S → EXT_PEND set at S+2 and INT_CU=1. W1C 8'h02 → INT_CU=0. INT_EXT held high produces no second set.
- Disable mid-count: RLD=16'h0100, CTRL=8'h01. After 20 cycles write CTRL=8'h00 → state ST_IDLE, and the P_CNT_LO value is frozen over 50 cycles. No TMR_PEND is set.
- Masking/decoding: TMR_PEND set with TMR_IE=0 → INT_CU=0. Then set TMR_IE → INT_CU=1 next cycle. A write to PORT_ID 8'hB6 changes no register.

Source files
------------

// File: rtl/rat_io_pkg.sv
// Shared definitions for RAT CPU port-mapped peripherals:
// port addresses, control/status bit positions and the timer state encoding.
package rat_io_pkg;

  localparam logic [7:0] P_RLD_LO = 8'hB0;
  localparam logic [7:0] P_RLD_HI = 8'hB1;
  localparam logic [7:0] P_CTRL   = 8'hB2;
  localparam logic [7:0] P_STAT   = 8'hB3;
  localparam logic [7:0] P_CNT_LO = 8'hB4;
  localparam logic [7:0] P_CNT_HI = 8'hB5;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_AUTO   = 1;
  localparam int CTRL_TMR_IE = 4;
  localparam int CTRL_EXT_IE = 5;

  localparam int STAT_TMR = 0;
  localparam int STAT_EXT = 1;
  localparam int STAT_RUN = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

endpackage

// File: rtl/rat_io_timer_int_if.sv
// RAT CPU port bus: the CPU drives strobe, address and write data,
// the peripheral returns read data for the addressed port.
interface rat_io_timer_int_if;

  logic       IO_STRB;
  logic [7:0] PORT_ID;
  logic [7:0] OUT_PORT;
  logic [7:0] IN_DATA;

  modport master (output IO_STRB, output PORT_ID, output OUT_PORT, input IN_DATA);
  modport slave  (input IO_STRB, input PORT_ID, input OUT_PORT, output IN_DATA);

endinterface

// File: rtl/rat_sync_edge.sv
// Two-flop synchronizer for an asynchronous level with a one-cycle
// rising-edge pulse taken from the synchronized side.
module rat_sync_edge
  import rat_io_pkg::*;
(
  input  logic CLK,
  input  logic RESET,
  input  logic async_in,
  output logic rise_pulse
);

  logic meta_r;
  logic sync_r;
  logic prev_r;

  // Synchronizer chain plus one delayed copy for edge detection
  always_ff @(posedge CLK) begin
    if (RESET) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
      prev_r <= 1'b0;
    end else begin
      meta_r <= async_in;
      sync_r <= meta_r;
      prev_r <= sync_r;
    end
  end

  assign rise_pulse = sync_r & ~prev_r;

endmodule

// File: rtl/rat_io_timer_int.sv
// Port-mapped prescaled down-counter and external event line, merged into
// a single maskable interrupt request for the RAT CONTROL_UNIT.
module rat_io_timer_int
  import rat_io_pkg::*;
#(
  parameter int PRESCALE = 50
)(
  input  logic                CLK,
  input  logic                RESET,
  rat_io_timer_int_if.slave   bus,
  input  logic                INT_EXT,
  output logic                INT_CU
);

  localparam int              PRE_W   = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);

  state_e           state_r;
  logic [15:0]      rld_r;
  logic [15:0]      count_r;
  logic [PRE_W-1:0] pre_r;
  logic             en_r;
  logic             auto_r;
  logic             tmr_ie_r;
  logic             ext_ie_r;
  logic             tmr_pend_r;
  logic             ext_pend_r;

  logic       wr_rld_lo_s;
  logic       wr_rld_hi_s;
  logic       wr_ctrl_s;
  logic       wr_stat_s;
  logic       tick_s;
  logic       expire_s;
  logic       ext_rise_s;
  logic [7:0] ctrl_byte_s;
  logic [7:0] stat_byte_s;
  logic [7:0] rd_data_s;

  assign wr_rld_lo_s = bus.IO_STRB && (bus.PORT_ID == P_RLD_LO);
  assign wr_rld_hi_s = bus.IO_STRB && (bus.PORT_ID == P_RLD_HI);
  assign wr_ctrl_s   = bus.IO_STRB && (bus.PORT_ID == P_CTRL);
  assign wr_stat_s   = bus.IO_STRB && (bus.PORT_ID == P_STAT);

  assign tick_s   = (pre_r == PRE_MAX);
  // A CTRL write takes priority over counting, so it also suppresses an expiry
  assign expire_s = (state_r == ST_RUN) && tick_s && (count_r == 16'h0000) && !wr_ctrl_s;

  rat_sync_edge u_ext_sync (
    .CLK        (CLK),
    .RESET      (RESET),
    .async_in   (INT_EXT),
    .rise_pulse (ext_rise_s)
  );

  // Reload value; takes effect only at the next load or periodic reload
  always_ff @(posedge CLK) begin
    if (RESET) begin
      rld_r <= 16'h0000;
    end else begin
      if (wr_rld_lo_s) rld_r[7:0]  <= bus.OUT_PORT;
      if (wr_rld_hi_s) rld_r[15:8] <= bus.OUT_PORT;
    end
  end

  // Control bits, prescaler, down-counter and state sequencing
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r  <= ST_IDLE;
      count_r  <= 16'h0000;
      pre_r    <= {PRE_W{1'b0}};
      en_r     <= 1'b0;
      auto_r   <= 1'b0;
      tmr_ie_r <= 1'b0;
      ext_ie_r <= 1'b0;
    end else if (wr_ctrl_s) begin
      en_r     <= bus.OUT_PORT[CTRL_EN];
      auto_r   <= bus.OUT_PORT[CTRL_AUTO];
      tmr_ie_r <= bus.OUT_PORT[CTRL_TMR_IE];
      ext_ie_r <= bus.OUT_PORT[CTRL_EXT_IE];
      state_r  <= bus.OUT_PORT[CTRL_EN] ? ST_LOAD : ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_r <= ST_IDLE;
        end
        ST_LOAD: begin
          count_r <= rld_r;
          pre_r   <= {PRE_W{1'b0}};
          state_r <= ST_RUN;
        end
        ST_RUN: begin
          if (tick_s) begin
            pre_r <= {PRE_W{1'b0}};
            if (count_r != 16'h0000) begin
              count_r <= count_r - 16'h0001;
            end else if (auto_r) begin
              count_r <= rld_r;
            end else begin
              en_r    <= 1'b0;
              state_r <= ST_IDLE;
            end
          end else begin
            pre_r <= pre_r + PRE_W'(1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Pending flags: a set on the same edge as a write-1-to-clear wins
  always_ff @(posedge CLK) begin
    if (RESET) begin
      tmr_pend_r <= 1'b0;
      ext_pend_r <= 1'b0;
    end else begin
      tmr_pend_r <= expire_s   | (tmr_pend_r & ~(wr_stat_s & bus.OUT_PORT[STAT_TMR]));
      ext_pend_r <= ext_rise_s | (ext_pend_r & ~(wr_stat_s & bus.OUT_PORT[STAT_EXT]));
    end
  end

  assign ctrl_byte_s = {2'b00, ext_ie_r, tmr_ie_r, 2'b00, auto_r, en_r};
  assign stat_byte_s = {5'b00000, (state_r == ST_RUN), ext_pend_r, tmr_pend_r};

  // Read mux; unmatched ports return zero so the board can OR read buses
  always_comb begin
    rd_data_s = 8'h00;
    case (bus.PORT_ID)
      P_RLD_LO: rd_data_s = rld_r[7:0];
      P_RLD_HI: rd_data_s = rld_r[15:8];
      P_CTRL:   rd_data_s = ctrl_byte_s;
      P_STAT:   rd_data_s = stat_byte_s;
      P_CNT_LO: rd_data_s = count_r[7:0];
      P_CNT_HI: rd_data_s = count_r[15:8];
      default:  rd_data_s = 8'h00;
    endcase
  end

  assign bus.IN_DATA = rd_data_s;
  assign INT_CU      = (tmr_pend_r & tmr_ie_r) | (ext_pend_r & ext_ie_r);

endmodule

// File: tb/tb_rat_io_timer_int.sv
// Bench for rat_io_timer_int: register table, timed corner-case sequences,
// then random port traffic checked against an arithmetic reference model.
module tb_rat_io_timer_int;
  import rat_io_pkg::*;

  localparam int P = 4;

  logic CLK     = 1'b0;
  logic RESET   = 1'b1;
  logic INT_EXT = 1'b0;
  logic INT_CU;

  rat_io_timer_int_if bus();

  rat_io_timer_int #(.PRESCALE(P)) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .bus     (bus),
    .INT_EXT (INT_EXT),
    .INT_CU  (INT_CU)
  );

  always #5 CLK = ~CLK;

  int edge_n = 0;
  always @(posedge CLK) edge_n <= edge_n + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [7:0] wr_id;
    logic [7:0] wr_dat;
    logic [7:0] rd_id;
    logic [7:0] exp;
  } vec_t;
  vec_t tbl [10];

  // Reference model: timer expressed as load edge plus elapsed ticks
  logic [15:0] m_rld, m_frozen;
  logic        m_en, m_auto, m_tie, m_eie, m_tp, m_ep, m_run, m_load, m_prev;
  int          m_base, m_rv, mn;
  int          m_q[$];

  logic       r_s, r_x;
  logic [7:0] r_id, r_d;
  int         e0, s0, frz;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @edge %0d: got %h, expected %h", name, edge_n, act, exp);
    end
  endtask

  task automatic chk_rd(input string name, input logic [7:0] id, input logic [7:0] exp);
    bus.PORT_ID = id;
    #1;
    chk(name, bus.IN_DATA, exp);
  endtask

  task automatic chk_int(input string name, input logic exp);
    chk(name, {7'd0, INT_CU}, {7'd0, exp});
  endtask

  task automatic wait_edge(input int x);
    while (edge_n < x) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic wr_at(input int x, input logic [7:0] id, input logic [7:0] d);
    wait_edge(x - 1);
    @(negedge CLK);
    bus.IO_STRB  = 1'b1;
    bus.PORT_ID  = id;
    bus.OUT_PORT = d;
    @(posedge CLK);
    #1;
    bus.IO_STRB  = 1'b0;
    bus.OUT_PORT = 8'h00;
  endtask

  task automatic wr(input logic [7:0] id, input logic [7:0] d);
    wr_at(edge_n + 1, id, d);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET = 1'b1;
    @(posedge CLK);
    @(posedge CLK);
    #1;
    RESET = 1'b0;
  endtask

  function automatic logic [15:0] m_cnt();
    return m_run ? 16'(m_rv - (mn - m_base) / P) : m_frozen;
  endfunction

  function automatic logic [7:0] m_rd(input logic [7:0] id);
    logic [15:0] c;
    c = m_cnt();
    case (id)
      P_RLD_LO: return m_rld[7:0];
      P_RLD_HI: return m_rld[15:8];
      P_CTRL:   return {2'b00, m_eie, m_tie, 2'b00, m_auto, m_en};
      P_STAT:   return {5'b00000, m_run, m_ep, m_tp};
      P_CNT_LO: return c[7:0];
      P_CNT_HI: return c[15:8];
      default:  return 8'h00;
    endcase
  endfunction

  function automatic logic m_int();
    return (m_tp & m_tie) | (m_ep & m_eie);
  endfunction

  task automatic m_reset();
    m_rld = 16'h0000; m_frozen = 16'h0000;
    m_en = 1'b0; m_auto = 1'b0; m_tie = 1'b0; m_eie = 1'b0;
    m_tp = 1'b0; m_ep = 1'b0; m_run = 1'b0; m_load = 1'b0; m_prev = 1'b0;
    m_base = 0; m_rv = 0; mn = 0;
    m_q.delete();
  endtask

  task automatic m_step(input logic s, input logic [7:0] id, input logic [7:0] d, input logic x);
    int          n;
    logic        wc, expire, ext_set;
    logic [15:0] cur;
    n       = mn + 1;
    wc      = s && (id == P_CTRL);
    cur     = m_cnt();
    expire  = m_run && !wc && ((n - m_base) == (m_rv + 1) * P);
    ext_set = 1'b0;
    if (wc) begin
      m_en = d[0]; m_auto = d[1]; m_tie = d[4]; m_eie = d[5];
      m_frozen = cur;
      m_run    = 1'b0;
      m_load   = d[0];
    end else if (m_load) begin
      m_load = 1'b0; m_run = 1'b1; m_base = n; m_rv = int'(m_rld);
    end else if (expire) begin
      if (m_auto) begin
        m_base = n; m_rv = int'(m_rld);
      end else begin
        m_run = 1'b0; m_en = 1'b0; m_frozen = 16'h0000;
      end
    end
    if (s && id == P_RLD_LO) m_rld[7:0]  = d;
    if (s && id == P_RLD_HI) m_rld[15:8] = d;
    if (m_q.size() > 0 && m_q[0] == n) begin
      void'(m_q.pop_front());
      ext_set = 1'b1;
    end
    if (x && !m_prev) m_q.push_back(n + 2);
    m_prev = x;
    m_tp = expire  | (m_tp & ~(s && id == P_STAT && d[0]));
    m_ep = ext_set | (m_ep & ~(s && id == P_STAT && d[1]));
    mn = n;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.IO_STRB  = 1'b0;
    bus.PORT_ID  = 8'h00;
    bus.OUT_PORT = 8'h00;
    tbl[0] = '{P_RLD_LO, 8'h5A, P_RLD_LO, 8'h5A};
    tbl[1] = '{P_RLD_HI, 8'hA5, P_RLD_HI, 8'hA5};
    tbl[2] = '{P_CTRL,   8'hFC, P_CTRL,   8'h30};
    tbl[3] = '{8'hB6,    8'hFF, P_RLD_LO, 8'h5A};
    tbl[4] = '{8'hB6,    8'h00, P_RLD_HI, 8'hA5};
    tbl[5] = '{P_CNT_LO, 8'h77, P_CNT_LO, 8'h00};
    tbl[6] = '{P_STAT,   8'hFF, P_STAT,   8'h00};
    tbl[7] = '{P_CNT_HI, 8'h12, P_CNT_HI, 8'h00};
    tbl[8] = '{8'hB7,    8'h33, 8'hB7,    8'h00};
    tbl[9] = '{P_CTRL,   8'h00, P_CTRL,   8'h00};

    do_reset();
    chk_int("reset_int", 1'b0);
    chk_rd("reset_ctrl", P_CTRL, 8'h00);
    chk_rd("reset_stat", P_STAT, 8'h00);
    chk_rd("reset_cnt_lo", P_CNT_LO, 8'h00);

    for (int i = 0; i < 10; i++) begin
      wr(tbl[i].wr_id, tbl[i].wr_dat);
      chk_rd($sformatf("table_%0d", i), tbl[i].rd_id, tbl[i].exp);
      chk_int($sformatf("table_int_%0d", i), 1'b0);
    end

    // One-shot, RELOAD=2: expiry at E0+1+3*P
    wr(P_RLD_LO, 8'h02);
    wr(P_RLD_HI, 8'h00);
    wr(P_CTRL, 8'h11);
    e0 = edge_n;
    wait_edge(e0 + 12);
    chk_int("oneshot_int_early", 1'b0);
    chk_rd("oneshot_stat_early", P_STAT, 8'h04);
    wait_edge(e0 + 13);
    chk_int("oneshot_int", 1'b1);
    chk_rd("oneshot_stat", P_STAT, 8'h01);
    chk_rd("oneshot_ctrl", P_CTRL, 8'h10);
    wait_edge(e0 + 20);
    chk_rd("oneshot_stat_hold", P_STAT, 8'h01);
    wr(P_STAT, 8'h01);
    chk_int("oneshot_ack_int", 1'b0);
    chk_rd("oneshot_ack_stat", P_STAT, 8'h00);

    // Periodic, RELOAD=1: expiries every 8 edges from E0+9
    wr(P_RLD_LO, 8'h01);
    wr(P_CTRL, 8'h13);
    e0 = edge_n;
    wait_edge(e0 + 8);
    chk_rd("period_pre", P_STAT, 8'h04);
    wait_edge(e0 + 9);
    chk_rd("period_1", P_STAT, 8'h05);
    chk_int("period_1_int", 1'b1);
    wr_at(e0 + 10, P_STAT, 8'h01);
    chk_rd("period_ack", P_STAT, 8'h04);
    chk_int("period_ack_int", 1'b0);
    wr_at(e0 + 17, P_STAT, 8'h01);
    chk_rd("period_set_wins", P_STAT, 8'h05);
    wr_at(e0 + 18, P_STAT, 8'h01);
    chk_rd("period_ack2", P_STAT, 8'h04);
    wait_edge(e0 + 24);
    chk_rd("period_3_pre", P_STAT, 8'h04);
    wait_edge(e0 + 25);
    chk_rd("period_3", P_STAT, 8'h05);
    wr(P_CTRL, 8'h00);
    wr(P_STAT, 8'h01);

    // External event: sampled high at S, pending at S+2
    wr(P_CTRL, 8'h20);
    s0 = edge_n + 1;
    @(negedge CLK);
    INT_EXT = 1'b1;
    wait_edge(s0 + 1);
    chk_int("ext_int_early", 1'b0);
    wait_edge(s0 + 2);
    chk_int("ext_int", 1'b1);
    chk_rd("ext_stat", P_STAT, 8'h02);
    wr(P_STAT, 8'h02);
    chk_int("ext_ack_int", 1'b0);
    wait_edge(edge_n + 10);
    chk_int("ext_held_int", 1'b0);
    chk_rd("ext_held_stat", P_STAT, 8'h00);
    INT_EXT = 1'b0;

    // Disable mid-count: count frozen at value after edge before the write
    wr(P_RLD_LO, 8'h00);
    wr(P_RLD_HI, 8'h01);
    wr(P_CTRL, 8'h01);
    e0 = edge_n;
    wr_at(e0 + 21, P_CTRL, 8'h00);
    frz = 256 - ((e0 + 20) - (e0 + 1)) / P;
    chk_rd("dis_stat", P_STAT, 8'h00);
    chk_rd("dis_cnt_lo", P_CNT_LO, 8'(frz));
    chk_rd("dis_cnt_hi", P_CNT_HI, 8'(frz >> 8));
    wait_edge(edge_n + 50);
    chk_rd("dis_cnt_lo_hold", P_CNT_LO, 8'(frz));
    chk_rd("dis_stat_hold", P_STAT, 8'h00);
    chk_int("dis_int", 1'b0);

    // Masking with RELOAD=0: expires on the first tick
    wr(P_RLD_HI, 8'h00);
    wr(P_RLD_LO, 8'h00);
    wr(P_CTRL, 8'h01);
    e0 = edge_n;
    wait_edge(e0 + 4);
    chk_rd("mask_stat_pre", P_STAT, 8'h04);
    wait_edge(e0 + 5);
    chk_rd("mask_stat", P_STAT, 8'h01);
    chk_int("mask_int_off", 1'b0);
    wr(P_CTRL, 8'h10);
    chk_int("mask_int_on", 1'b1);
    wr(8'hB6, 8'hFF);
    chk_rd("decode_ctrl", P_CTRL, 8'h10);
    chk_rd("decode_rld", P_RLD_LO, 8'h00);
    chk_rd("decode_stat", P_STAT, 8'h01);
    wr(P_STAT, 8'h01);
    chk_int("mask_ack", 1'b0);

    // Reset while running aborts with nothing pending
    wr(P_RLD_LO, 8'h02);
    wr(P_CTRL, 8'h11);
    e0 = edge_n;
    wait_edge(e0 + 6);
    do_reset();
    chk_int("rst_run_int", 1'b0);
    chk_rd("rst_run_stat", P_STAT, 8'h00);
    chk_rd("rst_run_rld", P_RLD_LO, 8'h00);
    wait_edge(edge_n + 20);
    chk_rd("rst_run_stat_late", P_STAT, 8'h00);
    chk_int("rst_run_int_late", 1'b0);

    // Random port traffic against the reference model
    m_reset();
    r_x = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge CLK);
      r_s  = ($urandom_range(0, 5) == 0);
      r_id = ($urandom_range(0, 7) == 0) ? 8'($urandom) : (8'hB0 + 8'($urandom_range(0, 7)));
      r_d  = 8'($urandom);
      if (r_id == P_RLD_HI && $urandom_range(0, 7) != 0) r_d = 8'h00;
      if (r_id == P_RLD_LO) r_d = r_d & 8'h07;
      if (r_id == P_CTRL && $urandom_range(0, 3) != 0) r_d[0] = 1'b1;
      if ($urandom_range(0, 9) == 0) r_x = ~r_x;
      bus.IO_STRB  = r_s;
      bus.PORT_ID  = r_id;
      bus.OUT_PORT = r_d;
      INT_EXT      = r_x;
      #1;
      chk($sformatf("rnd_rd_%0h", r_id), bus.IN_DATA, m_rd(r_id));
      chk("rnd_int", {7'd0, INT_CU}, {7'd0, m_int()});
      @(posedge CLK);
      m_step(r_s, r_id, r_d, r_x);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
